// File: rtl/micro_sequencer.sv
// micro_sequencer: next-microinstruction address selection for the
// microprogrammed control unit, with condition mux and return stack.
module micro_sequencer #(
    parameter int unsigned SW         = 7,
    parameter int unsigned NCOND      = 4,
    parameter int unsigned CSW        = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned FETCH_ADDR = 1,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold,
    input  logic [NCOND-1:0]         cond,
    input  logic [SW-1:0]            enc_addr,
    input  logic [SW-1:0]            cr,
    input  logic [CSW-1:0]           sel,
    input  logic                     inv,
    input  logic [2:0]               n,
    output logic [SW-1:0]            next_addr,
    output logic [SW-1:0]            upc,
    output logic                     cond_val,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     stack_full,
    output logic                     stack_empty,
    output logic                     ustack_err
);

    localparam int unsigned SPW = $clog2(DEPTH) + 1;

    localparam logic [2:0] OP_DECODE = 3'd0;
    localparam logic [2:0] OP_FETCH  = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_INC    = 3'd3;
    localparam logic [2:0] OP_CJMP   = 3'd4;
    localparam logic [2:0] OP_CWAIT  = 3'd5;
    localparam logic [2:0] OP_CALL   = 3'd6;
    localparam logic [2:0] OP_RET    = 3'd7;

    logic [SW-1:0]  upc_q, upc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic [SW-1:0]  stk_q [DEPTH];

    logic [SW-1:0]  inc;
    logic [SW-1:0]  top;
    logic           push, pop;
    logic           full, empty;

    assign inc   = upc_q + SW'(1);
    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);

    // Condition mux; out-of-range selects behave as a constant-0 condition.
    always_comb begin
        cond_val = inv;
        for (int unsigned i = 0; i < NCOND; i++) begin
            if (CSW'(i) == sel) cond_val = cond[i] ^ inv;
        end
    end

    // Stack top is the entry just below the occupancy pointer.
    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (SPW'(i + 1) == sp_q) top = stk_q[i];
        end
    end

    // Next-address selection and stack push/pop/error decisions.
    always_comb begin
        next_addr = inc;
        push      = 1'b0;
        pop       = 1'b0;
        err_d     = err_q;
        case (n)
            OP_DECODE: next_addr = enc_addr;
            OP_FETCH:  next_addr = SW'(FETCH_ADDR);
            OP_JUMP:   next_addr = cr;
            OP_INC:    next_addr = inc;
            OP_CJMP:   next_addr = cond_val ? cr : inc;
            OP_CWAIT:  next_addr = cond_val ? inc : upc_q;
            OP_CALL: begin
                next_addr = cr;
                if (full) err_d = 1'b1;
                else      push  = 1'b1;
            end
            OP_RET: begin
                if (empty) begin
                    next_addr = SW'(FETCH_ADDR);
                    err_d     = 1'b1;
                end else begin
                    next_addr = top;
                    pop       = 1'b1;
                end
            end
            default: next_addr = inc;
        endcase
    end

    // Occupancy and upc next-state.
    always_comb begin
        upc_d = next_addr;
        sp_d  = sp_q;
        if (push)     sp_d = sp_q + SPW'(1);
        else if (pop) sp_d = sp_q - SPW'(1);
    end

    // State registers; reset wins over hold, hold freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q <= SW'(RESET_ADDR);
            sp_q  <= '0;
            err_q <= 1'b0;
        end else if (!hold) begin
            upc_q <= upc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack storage, written at the current pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (!reset && !hold && push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (SPW'(i) == sp_q) stk_q[i] <= inc;
            end
        end
    end

    assign upc         = upc_q;
    assign sp          = sp_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign ustack_err  = err_q;

endmodule
